// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide controller that borrows the
// shared ALU for every add/subtract step and accumulates a {HI,LO} result.
// Multiply is shift-add and divide is restoring, with one iteration per cycle.
// Optional feature macro: MDU_SIGNED_EN enables signed ops when op_i[1]=1.
// It adds a local operand negate in IDLE and a one-cycle FIX state that
// re-signs the results.
module mdu_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [3:0]  ALU_ADD = 4'd0,
    parameter logic [3:0]  ALU_SUB = 4'd1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic [WIDTH-1:0]   alu_src1_o,
    output logic [WIDTH-1:0]   alu_src2_o,
    output logic [3:0]         alu_ctrl_o,
    input  logic [WIDTH-1:0]   alu_result_i
);

    localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef MDU_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2, S_FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    // acc_hi holds P_hi (mul) or the remainder (div); acc_lo holds P_lo or the quotient.
    logic [WIDTH-1:0]   acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0]   acc_lo_reg, acc_lo_next;
    // opnd holds the multiplicand (mul) or the divisor (div).
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    logic               is_div_reg, is_div_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;

    logic               carry;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   quo_sh;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MDU_SIGNED_EN
    logic               signed_reg, signed_next;
    logic               neg_res_reg, neg_res_next;
    logic               neg_rem_reg, neg_rem_next;
    logic [2*WIDTH-1:0] fix_prod;
`else
    logic               unused_sign;
    assign unused_sign = op_i[1];
`endif

    assign busy_o = (state_reg == S_ITER)
`ifdef MDU_SIGNED_EN
                    || (state_reg == S_FIX)
`endif
                    ;
    assign done_o = (state_reg == S_DONE);
    assign hi_o   = hi_reg;
    assign lo_o   = lo_reg;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MDU_SIGNED_EN
            signed_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            acc_hi_reg  <= acc_hi_next;
            acc_lo_reg  <= acc_lo_next;
            opnd_reg    <= opnd_next;
            is_div_reg  <= is_div_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
`ifdef MDU_SIGNED_EN
            signed_reg  <= signed_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
`endif
        end
    end

    // Next-state, ALU drive and one iteration of the shift-add / restoring step.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        opnd_next   = opnd_reg;
        is_div_next = is_div_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        alu_src1_o  = '0;
        alu_src2_o  = '0;
        alu_ctrl_o  = ALU_ADD;
        carry       = 1'b0;
        rem_sh      = '0;
        quo_sh      = '0;
        a_mag       = src1_i;
        b_mag       = src2_i;
`ifdef MDU_SIGNED_EN
        signed_next  = signed_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        fix_prod     = '0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
`ifdef MDU_SIGNED_EN
                    signed_next  = op_i[1];
                    neg_res_next = op_i[1] & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                    neg_rem_next = op_i[1] & src1_i[WIDTH-1];
                    if (op_i[1] && src1_i[WIDTH-1]) a_mag = -src1_i;
                    if (op_i[1] && src2_i[WIDTH-1]) b_mag = -src2_i;
`endif
                    state_next  = S_ITER;
                    count_next  = '0;
                    is_div_next = op_i[0];
                    acc_hi_next = '0;
                    acc_lo_next = op_i[0] ? a_mag : b_mag;
                    opnd_next   = op_i[0] ? b_mag : a_mag;
                end
            end
            S_ITER: begin
                if (is_div_reg) begin
                    rem_sh     = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
                    quo_sh     = {acc_lo_reg[WIDTH-2:0], 1'b0};
                    alu_src1_o = rem_sh[WIDTH-1:0];
                    alu_src2_o = opnd_reg;
                    alu_ctrl_o = ALU_SUB;
                    if (rem_sh[WIDTH] || (rem_sh[WIDTH-1:0] >= opnd_reg)) begin
                        acc_hi_next = alu_result_i;
                        acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_next = rem_sh[WIDTH-1:0];
                        acc_lo_next = quo_sh;
                    end
                end else begin
                    alu_src1_o  = acc_hi_reg;
                    alu_src2_o  = acc_lo_reg[0] ? opnd_reg : '0;
                    alu_ctrl_o  = ALU_ADD;
                    carry       = acc_lo_reg[0] && (alu_result_i < acc_hi_reg);
                    acc_hi_next = {carry, alu_result_i[WIDTH-1:1]};
                    acc_lo_next = {alu_result_i[0], acc_lo_reg[WIDTH-1:1]};
                end
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_CNT) begin
                    count_next = '0;
                    state_next = S_DONE;
                    hi_next    = acc_hi_next;
                    lo_next    = acc_lo_next;
`ifdef MDU_SIGNED_EN
                    if (signed_reg) begin
                        state_next = S_FIX;
                        hi_next    = hi_reg;
                        lo_next    = lo_reg;
                    end
`endif
                end
            end
`ifdef MDU_SIGNED_EN
            S_FIX: begin
                if (is_div_reg) begin
                    lo_next = neg_res_reg ? -acc_lo_reg : acc_lo_reg;
                    hi_next = neg_rem_reg ? -acc_hi_reg : acc_hi_reg;
                end else begin
                    fix_prod = {acc_hi_reg, acc_lo_reg};
                    if (neg_res_reg) fix_prod = -fix_prod;
                    hi_next = fix_prod[2*WIDTH-1:WIDTH];
                    lo_next = fix_prod[WIDTH-1:0];
                end
                state_next = S_DONE;
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
